// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if
//   Groups the event input and the stretched-pulse status outputs of
//   pulse_stretcher into one bundle.
//   Signals:
//     in       event input (one event per cycle sampled high)
//     out      stretched pulse output
//     busy     high while a window or gap is in progress
//     pending  number of queued events not yet started
//     overflow sticky dropped-event flag (only with PULSE_STRETCH_OVF_EN)
//   Modports: master = event source / observer, slave = pulse_stretcher.
interface pulse_stretcher_if #(
  parameter int PEND_W = 3
);
  logic              in;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
`ifdef PULSE_STRETCH_OVF_EN
  logic              overflow;

  modport master (output in, input out, input busy, input pending, input overflow);
  modport slave  (input in, output out, output busy, output pending, output overflow);
`else
  modport master (output in, input out, input busy, input pending);
  modport slave  (input in, output out, output busy, output pending);
`endif
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle event pulses into fixed-width level pulses: each
//   accepted event gives one HOLD_CYCLES-wide high window on out followed by
//   a GAP_CYCLES-wide low gap. Events arriving while a window or gap is in
//   progress are counted in a saturating pending counter and replayed.
//   Optional feature macro: PULSE_STRETCH_OVF_EN adds a sticky overflow flag
//   that is set when an event is dropped because pending is saturated.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  pulse_stretcher_if.slave (in, out, busy, pending[, overflow])
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  pulse_stretcher_if.slave   bus
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  // Timer counts down remaining edges of the current phase; zero marks the last edge.
  localparam logic [TMR_W-1:0]  HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [TMR_W-1:0]  timer_r, timer_s;
  logic [PEND_W-1:0] pending_r, pending_s;
  logic              out_r;
  logic              busy_r;
  logic              timer_done_s;
  logic              enq_s;
`ifdef PULSE_STRETCH_OVF_EN
  logic              overflow_r;
  logic              ovf_set_s;
`endif

  // Next-state, timer and pending-counter logic.
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r;
    pending_s    = pending_r;
    timer_done_s = (timer_r == TMR_ZERO);
    // An event is queued during HOLD and during every GAP edge except the last;
    // on the last GAP edge it is consumed directly by the decision below.
    enq_s        = bus.in && ((state_r == HOLD) || ((state_r == GAP) && !timer_done_s));
`ifdef PULSE_STRETCH_OVF_EN
    ovf_set_s    = 1'b0;
`endif

    if (enq_s) begin
      if (pending_r != PEND_MAX) begin
        pending_s = pending_r + PEND_ONE;
      end else begin
`ifdef PULSE_STRETCH_OVF_EN
        ovf_set_s = 1'b1;
`endif
        pending_s = pending_r;
      end
    end else begin
      pending_s = pending_r;
    end

    case (state_r)
      IDLE: begin
        if (bus.in) begin
          state_s = HOLD;
          timer_s = HOLD_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        if (timer_done_s) begin
          state_s = GAP;
          timer_s = GAP_LOAD;
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
      end
      GAP: begin
        if (timer_done_s) begin
          if (pending_r != PEND_ZERO) begin
            state_s = HOLD;
            timer_s = HOLD_LOAD;
            // A new event on this edge replaces the one being replayed.
            if (!bus.in) begin
              pending_s = pending_r - PEND_ONE;
            end else begin
              pending_s = pending_r;
            end
          end else if (bus.in) begin
            state_s = HOLD;
            timer_s = HOLD_LOAD;
          end else begin
            state_s = IDLE;
          end
        end else begin
          timer_s = timer_r - TMR_ONE;
        end
      end
      default: begin
        state_s   = IDLE;
        timer_s   = TMR_ZERO;
        pending_s = PEND_ZERO;
      end
    endcase
  end

  // State, timer, counter and registered outputs (out/busy decoded from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      timer_r   <= TMR_ZERO;
      pending_r <= PEND_ZERO;
      out_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      pending_r <= pending_s;
      out_r     <= (state_s == HOLD);
      busy_r    <= (state_s != IDLE);
    end
  end

`ifdef PULSE_STRETCH_OVF_EN
  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (ovf_set_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign bus.overflow = overflow_r;
`endif

  assign bus.out     = out_r;
  assign bus.busy    = busy_r;
  assign bus.pending = pending_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: a timeline-based reference model
// (window start time + pending count) checked every cycle, plus directed
// literal expectations and randomized stimulus.
module tb_pulse_stretcher;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 3;
  localparam int PMAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pulse_stretcher_if #(.PEND_W(PW)) bus ();

  pulse_stretcher #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .PEND_W     (PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a window that starts at edge m_start is high for edges
  // [m_start, m_start+H) and low until the decision edge m_start+H+G.
  int m_k      = 0;
  int m_start  = 0;
  bit m_active = 1'b0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;
  int m_rel;
  bit m_in;

  always @(posedge clk) begin
    m_in = bus.in;
    if (rst) begin
      m_active = 1'b0;
      m_pend   = 0;
      m_ovf    = 1'b0;
    end else begin
      m_k++;
      if (!m_active) begin
        if (m_in) begin
          m_active = 1'b1;
          m_start  = m_k;
        end
      end else begin
        m_rel = m_k - m_start;
        if (m_rel == H + G) begin
          if (m_pend > 0) begin
            m_pend  = m_pend - 1 + int'(m_in);
            m_start = m_k;
          end else if (m_in) begin
            m_start = m_k;
          end else begin
            m_active = 1'b0;
          end
        end else if (m_in) begin
          if (m_pend < PMAX) m_pend++;
          else m_ovf = 1'b1;
        end
      end
    end
    #1;
    check("model_out", int'(bus.out), int'(m_active && ((m_k - m_start) < H)));
    check("model_busy", int'(bus.busy), int'(m_active));
    check("model_pending", int'(bus.pending), m_pend);
`ifdef PULSE_STRETCH_OVF_EN
    check("model_overflow", int'(bus.overflow), int'(m_ovf));
`endif
  end

  // Drive in for one edge and land just after that edge.
  task automatic step(input bit v);
    @(negedge clk);
    bus.in = v;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic single_pulse(input string tag);
    step(1'b1);                                   // E0
    check({tag, "_e0_out"}, int'(bus.out), 1);
    check({tag, "_e0_busy"}, int'(bus.busy), 1);
    idle_steps(3);                                // E3
    check({tag, "_e3_out"}, int'(bus.out), 1);
    step(1'b0);                                   // E4
    check({tag, "_e4_out"}, int'(bus.out), 0);
    check({tag, "_e4_busy"}, int'(bus.busy), 1);
    step(1'b0);                                   // E5
    check({tag, "_e5_busy"}, int'(bus.busy), 1);
    step(1'b0);                                   // E6
    check({tag, "_e6_busy"}, int'(bus.busy), 0);
    check({tag, "_e6_pending"}, int'(bus.pending), 0);
  endtask

  int burst_left;

  initial begin
    bus.in = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_out", int'(bus.out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pending", int'(bus.pending), 0);
`ifdef PULSE_STRETCH_OVF_EN
    check("rst_overflow", int'(bus.overflow), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Quiet input keeps everything low.
    for (int i = 0; i < 100; i++) begin
      step(1'b0);
      check("quiet_out", int'(bus.out), 0);
      check("quiet_busy", int'(bus.busy), 0);
      check("quiet_pending", int'(bus.pending), 0);
    end

    single_pulse("single");

    // Three events E0..E2: replays start at E6 and E12, idle after E18.
    step(1'b1); step(1'b1); step(1'b1);           // E2
    check("three_e2_pending", int'(bus.pending), 2);
    idle_steps(4);                                // E6
    check("three_e6_out", int'(bus.out), 1);
    check("three_e6_pending", int'(bus.pending), 1);
    idle_steps(6);                                // E12
    check("three_e12_out", int'(bus.out), 1);
    check("three_e12_pending", int'(bus.pending), 0);
    idle_steps(4);                                // E16
    check("three_e16_out", int'(bus.out), 0);
    idle_steps(2);                                // E18
    check("three_e18_busy", int'(bus.busy), 0);

    // Event on the final gap edge with nothing pending chains directly.
    step(1'b1);
    idle_steps(5);                                // E5
    check("chain_e5_out", int'(bus.out), 0);
    step(1'b1);                                   // E6
    check("chain_e6_out", int'(bus.out), 1);
    check("chain_e6_pending", int'(bus.pending), 0);
    idle_steps(4);                                // E10
    check("chain_e10_out", int'(bus.out), 0);
    idle_steps(2);                                // E12
    check("chain_e12_busy", int'(bus.busy), 0);

    // Nine-cycle burst: E6 is a final gap edge, so pending reaches 7 at E8.
    for (int i = 0; i < 9; i++) step(1'b1);       // E8
    check("burst9_pending", int'(bus.pending), 7);
`ifdef PULSE_STRETCH_OVF_EN
    check("burst9_overflow", int'(bus.overflow), 0);
`endif
    idle_steps(70);
    check("burst9_drained", int'(bus.busy), 0);

    // Fourteen-cycle burst: saturates and drops events.
    for (int i = 0; i < 14; i++) step(1'b1);      // E13
    check("burst14_pending", int'(bus.pending), 7);
`ifdef PULSE_STRETCH_OVF_EN
    check("burst14_overflow", int'(bus.overflow), 1);
`endif
    idle_steps(100);
    check("burst14_drained", int'(bus.busy), 0);
`ifdef PULSE_STRETCH_OVF_EN
    check("overflow_sticky", int'(bus.overflow), 1);
`endif

    // Asynchronous reset mid-HOLD with three events pending.
    for (int i = 0; i < 4; i++) step(1'b1);       // E3
    check("prerst_pending", int'(bus.pending), 3);
    check("prerst_out", int'(bus.out), 1);
    @(negedge clk);
    bus.in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", int'(bus.out), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_pending", int'(bus.pending), 0);
`ifdef PULSE_STRETCH_OVF_EN
    check("async_rst_overflow", int'(bus.overflow), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    single_pulse("after_rst");

    // Randomized traffic with occasional bursts and resets.
    burst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if (burst_left > 0) begin
        bus.in = 1'b1;
        burst_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        burst_left = $urandom_range(2, 14);
        bus.in = 1'b1;
      end else begin
        bus.in = ($urandom_range(0, 5) == 0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in = 1'b0;
    idle_steps(120);
    check("final_idle", int'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
